// File: rtl/timer_tick_ctrl.sv
// timer_tick_ctrl: countdown tick/load/expiry controller for a digit-counter chain; optional blinking alarm via `TIMER_ALARM_EN
module timer_tick_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int LOAD_CYCLES = 2,
  parameter int ALARM_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic loadReq,
  input  logic start,
  input  logic pause,
  input  logic noBorrowDownIn,
  output logic reconfig,
  output logic borrowDown,
  output logic noBorrowUp,
  output logic running,
  output logic timeUp,
  output logic alarm
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSED, EXPIRED} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d, presc_inc;
  logic [3:0] lcnt_q, lcnt_d;
  logic [1:0] guard_q, guard_d;
  logic nb_q, nb_d, tu_q, tu_d;
  logic tc, load_done, expire, presc_run;
  assign tc        = presc_q == TERM;
  assign presc_inc = tc ? '0 : presc_q + PW'(1);
  assign load_done = lcnt_q == 4'(LOAD_CYCLES - 1);
  assign expire    = noBorrowDownIn && nb_q && guard_q == 2'd2;
`ifdef TIMER_ALARM_EN
  assign presc_run = (state_q == RUN && state_d == RUN) || (state_q == EXPIRED && state_d == EXPIRED);
`else
  assign presc_run = state_q == RUN && state_d == RUN;
`endif
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next-state logic; loadReq outranks start in IDLE, expiry outranks pause in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = loadReq ? LOAD : start ? RUN : IDLE;
      LOAD:    state_d = load_done ? IDLE : LOAD;
      RUN:     state_d = expire ? EXPIRED : pause ? PAUSED : RUN;
      PAUSED:  state_d = (start && !pause) ? RUN : PAUSED;
      EXPIRED: state_d = loadReq ? LOAD : EXPIRED;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state; a pause request masks the tick in the same cycle
  always_comb begin
    reconfig   = state_q == LOAD;
    borrowDown = state_q == RUN && tc && !pause;
    noBorrowUp = 1'b1;
    running    = state_q == RUN;
    timeUp     = tu_q;
  end
  // datapath next values: prescaler holds across pause, expiry needs two consecutive exhausted samples after a 2-cycle guard
  always_comb begin
    presc_d = presc_run ? presc_inc : (state_q == PAUSED || state_d == PAUSED) ? presc_q : '0;
    lcnt_d  = state_q == LOAD ? lcnt_q + 4'd1 : 4'd0;
    guard_d = state_q == RUN ? (guard_q == 2'd2 ? guard_q : guard_q + 2'd1) : state_q == PAUSED ? guard_q : 2'd0;
    nb_d    = state_q == RUN && noBorrowDownIn;
    tu_d    = state_q == RUN && state_d == EXPIRED;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      lcnt_q  <= '0;
      guard_q <= '0;
      nb_q    <= 1'b0;
      tu_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      lcnt_q  <= lcnt_d;
      guard_q <= guard_d;
      nb_q    <= nb_d;
      tu_q    <= tu_d;
    end
  end
`ifdef TIMER_ALARM_EN
  localparam int AW = $clog2(ALARM_TICKS + 2);
  logic [AW-1:0] tcnt_q, tcnt_d;
  logic alarm_q, alarm_d, blink;
  assign blink = state_q == EXPIRED && tc && tcnt_q < AW'(ALARM_TICKS);
  assign alarm = alarm_q;
  // alarm lights on expiry, toggles on each prescaler wrap for a fixed count, then stays lit
  always_comb begin
    alarm_d = state_d != EXPIRED ? 1'b0 : state_q != EXPIRED ? 1'b1 : blink ? !alarm_q : alarm_q;
    tcnt_d  = state_q != EXPIRED ? '0 : blink ? tcnt_q + AW'(1) : tcnt_q;
  end
  // alarm registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      tcnt_q  <= tcnt_d;
    end
  end
`else
  assign alarm = state_q == EXPIRED;
`endif
endmodule

// File: tb/tb_timer_tick_ctrl.sv
// tb_timer_tick_ctrl: directed tests for timer_tick_ctrl with TICK_DIV=4, LOAD_CYCLES=2, ALARM_TICKS=8
module tb_timer_tick_ctrl;
  logic clk = 1'b0, rst = 1'b1, loadReq = 1'b0, start = 1'b0, pause = 1'b0, nbd = 1'b0;
  logic reconfig, borrowDown, noBorrowUp, running, timeUp, alarm;
  logic [5:0] outs, exp;
  int vecs = 0, errs = 0;
  localparam logic [5:0] O_IDLE = 6'b001000;
  localparam logic [5:0] O_LOAD = 6'b101000;
  localparam logic [5:0] O_RUN  = 6'b001100;
  localparam logic [5:0] O_BD   = 6'b011100;
  localparam logic [5:0] O_TU   = 6'b001011;
  localparam logic [5:0] O_EXP  = 6'b001001;
  timer_tick_ctrl #(.TICK_DIV(4), .LOAD_CYCLES(2), .ALARM_TICKS(8)) dut (
    .clk(clk), .rst(rst), .loadReq(loadReq), .start(start), .pause(pause),
    .noBorrowDownIn(nbd), .reconfig(reconfig), .borrowDown(borrowDown),
    .noBorrowUp(noBorrowUp), .running(running), .timeUp(timeUp), .alarm(alarm)
  );
  assign outs = {reconfig, borrowDown, noBorrowUp, running, timeUp, alarm};
  always #5 clk = ~clk;
  task automatic go;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; loadReq = 1'b0; start = 1'b0; pause = 1'b0; nbd = 1'b0;
    go;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; loadReq = 1'b1; start = 1'b1;
    go;
    loadReq = 1'b0; start = 1'b0;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL reset_values: outs=%b expected %b", outs, O_IDLE); end
    rst = 1'b0;
    go;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL reset_idle_hold: outs=%b expected %b", outs, O_IDLE); end
  endtask
  task automatic test_load;
    do_reset;
    loadReq = 1'b1; start = 1'b1;
    go;
    loadReq = 1'b0; pause = 1'b1;
    #1; vecs++; if (outs !== O_LOAD) begin errs++; $display("FAIL load_c1: outs=%b expected %b", outs, O_LOAD); end
    go;
    #1; vecs++; if (outs !== O_LOAD) begin errs++; $display("FAIL load_c2: outs=%b expected %b", outs, O_LOAD); end
    go;
    start = 1'b0; pause = 1'b0;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL load_done: outs=%b expected %b", outs, O_IDLE); end
    go;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL load_start_ignored: outs=%b expected %b", outs, O_IDLE); end
  endtask
  task automatic test_tick;
    do_reset;
    start = 1'b1;
    go;
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      exp = (c % 4 == 0) ? O_BD : O_RUN;
      #1; vecs++; if (outs !== exp) begin errs++; $display("FAIL tick_c%0d: outs=%b expected %b", c, outs, exp); end
      go;
    end
  endtask
  task automatic test_pause;
    do_reset;
    start = 1'b1;
    go;
    start = 1'b0;
    go; go;
    pause = 1'b1;
    #1; vecs++; if (outs !== O_RUN) begin errs++; $display("FAIL pause_at_2: outs=%b expected %b", outs, O_RUN); end
    go;
    for (int i = 0; i < 10; i++) begin
      start = (i == 5);
      #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL paused_%0d: outs=%b expected %b", i, outs, O_IDLE); end
      go;
    end
    pause = 1'b0; start = 1'b1;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL resume_req: outs=%b expected %b", outs, O_IDLE); end
    go;
    start = 1'b0;
    #1; vecs++; if (outs !== O_RUN) begin errs++; $display("FAIL resume_c1: outs=%b expected %b", outs, O_RUN); end
    go;
    #1; vecs++; if (outs !== O_BD) begin errs++; $display("FAIL resume_c2: outs=%b expected %b", outs, O_BD); end
    go; go; go; go;
    pause = 1'b1;
    #1; vecs++; if (outs !== O_RUN) begin errs++; $display("FAIL pause_at_tc: outs=%b expected %b", outs, O_RUN); end
    go;
    pause = 1'b0; start = 1'b1;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL paused_tc: outs=%b expected %b", outs, O_IDLE); end
    go;
    start = 1'b0;
    #1; vecs++; if (outs !== O_BD) begin errs++; $display("FAIL resume_at_tc: outs=%b expected %b", outs, O_BD); end
    go;
    #1; vecs++; if (outs !== O_RUN) begin errs++; $display("FAIL wrap_after_tc: outs=%b expected %b", outs, O_RUN); end
  endtask
  task automatic test_expire;
    do_reset;
    start = 1'b1;
    go;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      nbd = (c == 4 || c == 8 || c == 9);
      exp = (c % 4 == 0) ? O_BD : O_RUN;
      #1; vecs++; if (outs !== exp) begin errs++; $display("FAIL expire_run_c%0d: outs=%b expected %b", c, outs, exp); end
      go;
    end
    nbd = 1'b0;
    #1; vecs++; if (outs !== O_TU) begin errs++; $display("FAIL timeup_pulse: outs=%b expected %b", outs, O_TU); end
    go;
    start = 1'b1;
    #1; vecs++; if (outs !== O_EXP) begin errs++; $display("FAIL timeup_single: outs=%b expected %b", outs, O_EXP); end
    go;
    start = 1'b0;
    #1; vecs++; if (outs !== O_EXP) begin errs++; $display("FAIL expired_start_ignored: outs=%b expected %b", outs, O_EXP); end
    loadReq = 1'b1;
    go;
    loadReq = 1'b0;
    #1; vecs++; if (outs !== O_LOAD) begin errs++; $display("FAIL expired_load: outs=%b expected %b", outs, O_LOAD); end
    go; go;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL expired_load_idle: outs=%b expected %b", outs, O_IDLE); end
  endtask
  task automatic test_zero_load;
    do_reset;
    nbd = 1'b1; start = 1'b1;
    go;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1; vecs++; if (outs !== O_RUN) begin errs++; $display("FAIL zero_guard_c%0d: outs=%b expected %b", c, outs, O_RUN); end
      go;
    end
    #1; vecs++; if (outs !== O_TU) begin errs++; $display("FAIL zero_expire: outs=%b expected %b", outs, O_TU); end
    go;
    nbd = 1'b0;
    #1; vecs++; if (outs !== O_EXP) begin errs++; $display("FAIL zero_expired: outs=%b expected %b", outs, O_EXP); end
  endtask
  task automatic test_reset_mid;
    do_reset;
    start = 1'b1;
    go;
    start = 1'b0;
    go; go; go;
    rst = 1'b1;
    #1; vecs++; if (outs !== O_BD) begin errs++; $display("FAIL rst_run_tc: outs=%b expected %b", outs, O_BD); end
    go;
    rst = 1'b0;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL rst_run_abort: outs=%b expected %b", outs, O_IDLE); end
    go; go; go;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL rst_run_residual: outs=%b expected %b", outs, O_IDLE); end
    loadReq = 1'b1;
    go;
    loadReq = 1'b0;
    #1; vecs++; if (outs !== O_LOAD) begin errs++; $display("FAIL rst_load_enter: outs=%b expected %b", outs, O_LOAD); end
    rst = 1'b1;
    go;
    rst = 1'b0;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL rst_load_abort: outs=%b expected %b", outs, O_IDLE); end
    go;
    #1; vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL rst_load_residual: outs=%b expected %b", outs, O_IDLE); end
  endtask
`ifdef TIMER_ALARM_EN
  task automatic test_alarm;
    int n;
    do_reset;
    nbd = 1'b1; start = 1'b1;
    go;
    start = 1'b0;
    go; go; go;
    nbd = 1'b0;
    for (int c = 4; c <= 44; c++) begin
      n = (c - 4) / 4;
      if (n > 8) n = 8;
      exp = {3'b001, 1'b0, c == 4, n % 2 == 0};
      #1; vecs++; if (outs !== exp) begin errs++; $display("FAIL alarm_c%0d: outs=%b expected %b", c, outs, exp); end
      go;
    end
    loadReq = 1'b1;
    go;
    loadReq = 1'b0;
    #1; vecs++; if (outs !== O_LOAD) begin errs++; $display("FAIL alarm_clear: outs=%b expected %b", outs, O_LOAD); end
  endtask
`endif
  initial begin
    test_reset;
    test_load;
    test_tick;
    test_pause;
    test_expire;
    test_zero_load;
    test_reset_mid;
`ifdef TIMER_ALARM_EN
    test_alarm;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
